// File: rtl/pipe_mux.sv
// pipe_mux: N-channel registered multiplexer with valid/ready on every channel and on the output.
// Optional one-entry skid buffer (full throughput, registered in_ready) when PIPE_MUX_SKID_EN is defined.
module pipe_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      err_clr,
  output logic                      sel_err
);

  localparam logic [SEL_W:0] CHAN_L = (SEL_W+1)'(CHANNELS);

`ifdef PIPE_MUX_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1} state_t;
`endif

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH-1:0]     out_data_r;
  logic                 out_valid_r;
  logic                 sel_err_r;
  logic                 sel_ok_s;
  logic                 space_s;
  logic [CHANNELS-1:0]  in_ready_s;
  logic [WIDTH-1:0]     sel_data_s;
  logic                 in_fire_s;
  logic                 out_fire_s;
  logic                 load_main_s;
  logic [WIDTH-1:0]     main_next_s;
`ifdef PIPE_MUX_SKID_EN
  logic [WIDTH-1:0]     skid_data_r;
  logic                 skid_full_r;
  logic                 load_skid_s;
`endif

`ifdef PIPE_MUX_SKID_EN
  // Ready comes only from a register, breaking the out_ready -> in_ready path.
  assign space_s = ~skid_full_r;
`else
  assign space_s = ~out_valid_r | out_ready;
`endif

  // Channel decode: AND-OR data mux and one-hot ready for the selected channel.
  always_comb begin
    sel_ok_s   = ({1'b0, sel} < CHAN_L);
    sel_data_s = '0;
    in_ready_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready_s[i] = (sel == SEL_W'(i)) & space_s;
      sel_data_s    = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{sel == SEL_W'(i)}});
    end
  end

  assign in_fire_s  = |(in_valid & in_ready_s);
  assign out_fire_s = out_valid_r & out_ready;

  // Output-stage next state and load controls.
  always_comb begin
    state_s     = state_r;
    load_main_s = 1'b0;
    main_next_s = sel_data_s;
`ifdef PIPE_MUX_SKID_EN
    load_skid_s = 1'b0;
`endif
    case (state_r)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_s     = ST_FULL;
          load_main_s = 1'b1;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (in_fire_s && out_fire_s) begin
          state_s     = ST_FULL;
          load_main_s = 1'b1;
`ifdef PIPE_MUX_SKID_EN
        end else if (in_fire_s) begin
          state_s     = ST_SKID;
          load_skid_s = 1'b1;
`else
        end else if (in_fire_s) begin
          // Unreachable: a fire while full implies out_ready in this build.
          state_s     = ST_FULL;
          load_main_s = 1'b1;
`endif
        end else if (out_fire_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_FULL;
        end
      end
`ifdef PIPE_MUX_SKID_EN
      ST_SKID: begin
        if (out_fire_s) begin
          state_s     = ST_FULL;
          load_main_s = 1'b1;
          main_next_s = skid_data_r;
        end else begin
          state_s = ST_SKID;
        end
      end
`endif
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Output stage registers; reset discards any held word at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s != ST_EMPTY);
      if (load_main_s) begin
        out_data_r <= main_next_s;
      end
    end
  end

`ifdef PIPE_MUX_SKID_EN
  // Skid entry holds the word accepted while the main register was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full_r <= 1'b0;
      skid_data_r <= '0;
    end else begin
      skid_full_r <= (state_s == ST_SKID);
      if (load_skid_s) begin
        skid_data_r <= sel_data_s;
      end
    end
  end
`endif

  // Sticky out-of-range select flag; a new error wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_r <= 1'b0;
    end else if (!sel_ok_s && (|in_valid)) begin
      sel_err_r <= 1'b1;
    end else if (err_clr) begin
      sel_err_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_pipe_mux.sv
// Self-checking bench for pipe_mux: a negedge scoreboard tracks accepted words and expected
// readiness, while per-scenario tasks check the specific behaviours inline.
module tb_pipe_mux;
  localparam int WIDTH = 32;
  localparam int CH    = 3;
  localparam int SW    = 2;
`ifdef PIPE_MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW-1:0]     sel;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              err_clr;
  logic              sel_err;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sbq[$];

  pipe_mux #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_clr(err_clr), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  // Scoreboard: expected readiness from model occupancy, in-order data check.
  always @(negedge clk) begin
    logic [CH-1:0] exp_rdy;
    logic          space;
    int            occ;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      occ   = sbq.size();
      space = SKID ? (occ < 2) : ((occ == 0) || out_ready);
      exp_rdy = '0;
      for (int i = 0; i < CH; i++) exp_rdy[i] = (int'(sel) == i) && space;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL mon_in_ready got %b exp %b at %0t", in_ready, exp_rdy, $time);
      end
      checks++;
      if (out_valid !== (occ > 0)) begin
        errors++; $display("FAIL mon_out_valid got %b exp %b at %0t", out_valid, (occ > 0), $time);
      end
      if (occ > 0) begin
        checks++;
        if (out_data !== sbq[0]) begin
          errors++; $display("FAIL mon_out_data got %h exp %h at %0t", out_data, sbq[0], $time);
        end
        if (out_ready) void'(sbq.pop_front());
      end
      if ((exp_rdy != '0) && in_valid[sel]) sbq.push_back(in_data[int'(sel)*WIDTH +: WIDTH]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 2'd1; in_valid = '0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
    #12;
    checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL reset_in_ready got %b exp 010", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    sel = 2'd1; in_data = '0; in_data[WIDTH +: WIDTH] = 32'h0000_0005; in_valid = 3'b010;
    #1;
    checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL single_in_ready got %b exp 010", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 32'h5) begin errors++; $display("FAIL single_out_data got %h exp 5", out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    sel = 2'd2; out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data[2*WIDTH +: WIDTH] = 32'(k); in_valid = 3'b100;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(k)) begin
        errors++; $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, 32'(k));
      end
    end
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] words[2];
    logic [WIDTH-1:0] got[$];
    int idx = 0;
    words[0] = 32'hA; words[1] = 32'hB;
    out_ready = 1'b0; sel = 2'd0;
    for (int c = 0; c < 3; c++) begin
      if (idx < 2) begin in_data[0 +: WIDTH] = words[idx]; in_valid = 3'b001; end
      else in_valid = '0;
      @(negedge clk);
      if (in_ready[0] && in_valid[0]) idx++;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA) begin
        errors++; $display("FAIL bp_hold cycle%0d got v=%b d=%h exp v=1 d=a", c, out_valid, out_data);
      end
    end
    checks++; if (idx != (SKID ? 2 : 1)) begin errors++; $display("FAIL bp_accepted got %0d exp %0d", idx, SKID ? 2 : 1); end
    if (idx < 2) begin in_data[0 +: WIDTH] = words[idx]; in_valid = 3'b001; end
    else in_valid = '0;
    #1;
    checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL bp_stall got %b exp 000", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got.size() < 2; c++) begin
      @(negedge clk);
      if (in_ready[0] && in_valid[0]) idx++;
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      if (idx < 2) begin in_data[0 +: WIDTH] = words[idx]; in_valid = 3'b001; end
      else in_valid = '0;
    end
    checks++;
    if (got.size() != 2) begin errors++; $display("FAIL bp_release count got %0d exp 2", got.size()); end
    else if (got[0] !== 32'hA || got[1] !== 32'hB) begin
      errors++; $display("FAIL bp_order got %h,%h exp a,b", got[0], got[1]);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_sel_err();
    out_ready = 1'b1; sel = 2'd3; in_data = {32'h33, 32'h22, 32'h11}; in_valid = 3'b111;
    #1;
    checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL selerr_in_ready got %b exp 000", in_ready); end
    tick();
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_set got %b exp 1", sel_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL selerr_no_out got %b exp 0", out_valid); end
    err_clr = 1'b1;
    tick();
    checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL selerr_set_wins got %b exp 1", sel_err); end
    sel = 2'd0; in_valid = '0;
    tick();
    err_clr = 1'b0;
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL selerr_clear got %b exp 0", sel_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sel = 2'd0; in_data[0 +: WIDTH] = 32'hDEAD; in_valid = 3'b001;
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEAD) begin
      errors++; $display("FAIL rstmid_full got v=%b d=%h exp v=1 d=dead", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h exp 0", out_data); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %b exp 0", out_valid); end
  endtask

  task automatic test_sel_switch();
    int  n = 0;
    bit  stalled = 1'b0;
    bit  got_first = 1'b0;
    bit  seen_rdy = 1'b0;
    logic [WIDTH-1:0] first_word = '0;
    out_ready = 1'b0; sel = 2'd0;
    for (int c = 0; c < 6 && !stalled; c++) begin
      in_data[0 +: WIDTH] = 32'h100 + 32'(n); in_valid = 3'b001;
      @(negedge clk);
      if (in_ready[0]) n++; else stalled = 1'b1;
      tick();
    end
    checks++; if (!stalled || n != (SKID ? 2 : 1)) begin
      errors++; $display("FAIL switch_fill got stalled=%0d n=%0d exp stalled=1 n=%0d", stalled, n, SKID ? 2 : 1);
    end
    sel = 2'd1; in_data[WIDTH +: WIDTH] = 32'h33; in_valid = 3'b011;
    #1;
    checks++; if (in_ready !== 3'b000) begin errors++; $display("FAIL switch_no_space got %b exp 000", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && !got_first) begin got_first = 1'b1; first_word = out_data; end
      if (!seen_rdy && in_ready != '0) begin
        seen_rdy = 1'b1;
        checks++; if (in_ready !== 3'b010) begin errors++; $display("FAIL switch_ready got %b exp 010", in_ready); end
      end
      tick();
      if (seen_rdy) in_valid = 3'b001;
    end
    checks++; if (!got_first || first_word !== 32'h100) begin
      errors++; $display("FAIL switch_first got %h (seen=%0d) exp 100", first_word, got_first);
    end
    checks++; if (!seen_rdy) begin errors++; $display("FAIL switch_ready_seen got 0 exp 1"); end
    in_valid = '0;
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL switch_drain got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_sel_err();
    test_reset_mid();
    test_sel_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
